// File: rtl/ahb_mtx_l1_in_stage.sv
// rtl/ahb_mtx_l1_in_stage.sv - L1 AHB matrix input stage with address-phase holding register
// Optional feature macro: AHB_MTX_L1_IN_SEQ2NONSEQ_EN (held SEQ replayed as NONSEQ)
module ahb_mtx_l1_in_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HREADYS,
    output logic              HREADYOUTS,
    output logic [1:0]        HRESPS,
    output logic              sel_in,
    output logic [ADDR_W-1:0] addr_in,
    output logic [1:0]        trans_in,
    output logic              write_in,
    output logic [2:0]        size_in,
    output logic [2:0]        burst_in,
    output logic [3:0]        prot_in,
    output logic              ready_in,
    output logic              held_tran,
    input  logic              active_dec,
    input  logic              readyout_dec,
    input  logic [1:0]        resp_dec
);

    localparam logic [0:0] ST_PASS = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]        pend;
    logic              dphase;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        trans_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic [2:0]        burst_q;
    logic [3:0]        prot_q;
    logic              new_tran;
    logic              holding;
    logic [1:0]        trans_hold;

    assign new_tran = HSELS & HTRANSS[1] & HREADYS;
    assign holding  = (pend == ST_HOLD);

`ifdef AHB_MTX_L1_IN_SEQ2NONSEQ_EN
    // Arbitration may have split the burst, so a replayed SEQ restarts as NONSEQ
    assign trans_hold = (trans_q == 2'b11) ? 2'b10 : trans_q;
`else
    assign trans_hold = trans_q;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend    <= ST_PASS;
            dphase  <= 1'b0;
            addr_q  <= '0;
            trans_q <= 2'b00;
            write_q <= 1'b0;
            size_q  <= 3'b000;
            burst_q <= 3'b000;
            prot_q  <= 4'b0000;
        end else if (!holding) begin
            if (new_tran && !active_dec) begin
                pend    <= ST_HOLD;
                dphase  <= 1'b0;
                addr_q  <= HADDRS;
                trans_q <= HTRANSS;
                write_q <= HWRITES;
                size_q  <= HSIZES;
                burst_q <= HBURSTS;
                prot_q  <= HPROTS;
            end else if (new_tran) begin
                dphase <= 1'b1;
            end else if (HREADYS) begin
                dphase <= 1'b0;
            end
        end else if (active_dec) begin
            pend   <= ST_PASS;
            dphase <= 1'b1;
        end
    end

    assign sel_in    = holding ? 1'b1       : HSELS;
    assign addr_in   = holding ? addr_q     : HADDRS;
    assign trans_in  = holding ? trans_hold : HTRANSS;
    assign write_in  = holding ? write_q    : HWRITES;
    assign size_in   = holding ? size_q     : HSIZES;
    assign burst_in  = holding ? burst_q    : HBURSTS;
    assign prot_in   = holding ? prot_q     : HPROTS;
    assign ready_in  = holding ? active_dec : HREADYS;
    assign held_tran = holding;

    // The master is stalled for every HOLD cycle; the decoder only answers once a data phase is open
    assign HREADYOUTS = holding ? 1'b0 : (dphase ? readyout_dec : 1'b1);
    assign HRESPS     = (dphase && !holding) ? resp_dec : 2'b00;

endmodule
